uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/baud_gen_rx.sv | 37 +++
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, line-rate encoding
// and the oversample tick terminal counts.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_CNT_W = 11;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_rate_e;

    // Counter wraps after TC, so one tick period is TC+1 clocks at 50 MHz.
    localparam logic [TICK_CNT_W-1:0] TC_2400  = 11'd1301;
    localparam logic [TICK_CNT_W-1:0] TC_4800  = 11'd650;
    localparam logic [TICK_CNT_W-1:0] TC_9600  = 11'd325;
    localparam logic [TICK_CNT_W-1:0] TC_19200 = 11'd162;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [3:0] MID_BIT_TICK = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK    = 4'(OVERSAMPLE - 1);

    function automatic logic [TICK_CNT_W-1:0] terminal_count(input baud_rate_e rate);
        logic [TICK_CNT_W-1:0] tc;
        case (rate)
            BAUD_2400:  tc = TC_2400;
            BAUD_4800:  tc = TC_4800;
            BAUD_9600:  tc = TC_9600;
            default:    tc = TC_19200;
        endcase
        return tc;
    endfunction

endpackage

// File: rtl/baud_gen_rx.sv
// 16x oversample tick generator for the receiver; clear realigns the tick
// phase to the detected start edge.
module baud_gen_rx
    import uart_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  baud_rate_e rate,
    output logic       tick
);

    logic [TICK_CNT_W-1:0] cnt_q;
    logic [TICK_CNT_W-1:0] cnt_d;
    logic [TICK_CNT_W-1:0] tc;

    always_comb begin
        tc    = terminal_count(rate);
        tick  = 1'b0;
        cnt_d = cnt_q + TICK_CNT_W'(1);
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == tc) begin
            tick  = 1'b1;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit,
// sampled mid-bit from a 16x oversample tick aligned to the start edge.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] baud_rate,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       rx_serial,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       rx_busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rx_sync;

    rx_state_e  state_q,    state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_idx_q,  bit_idx_d;
    logic [7:0] shift_q,    shift_d;
    baud_rate_e rate_q,     rate_d;
    logic       par_en_q,   par_en_d;
    logic       par_odd_q,  par_odd_d;
    logic       par_err_pend_q, par_err_pend_d;

    logic [7:0] data_out_q,      data_out_d;
    logic       data_valid_q,    data_valid_d;
    logic       parity_error_q,  parity_error_d;
    logic       framing_error_q, framing_error_d;

    logic baud_clear;
    logic tick;

    // Synchronizer chain; flops reset to the idle line level.
    assign sync_d[0] = rx_serial;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate
    assign rx_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    baud_gen_rx u_baud_gen (
        .clock (clock),
        .reset (reset),
        .clear (baud_clear),
        .rate  (rate_q),
        .tick  (tick)
    );

    always_comb begin
        state_d         = state_q;
        tick_cnt_d      = tick_cnt_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        rate_d          = rate_q;
        par_en_d        = par_en_q;
        par_odd_d       = par_odd_q;
        par_err_pend_d  = par_err_pend_q;
        data_out_d      = data_out_q;
        data_valid_d    = 1'b0;
        parity_error_d  = parity_error_q;
        framing_error_d = framing_error_q;
        baud_clear      = 1'b0;

        case (state_q)
            IDLE: begin
                // Holding the tick counter cleared makes bit phase start at the edge.
                baud_clear = 1'b1;
                tick_cnt_d = '0;
                bit_idx_d  = '0;
                if (!rx_sync) begin
                    state_d        = START;
                    rate_d         = baud_rate_e'(baud_rate);
                    par_en_d       = parity_en;
                    par_odd_d      = parity_odd;
                    par_err_pend_d = 1'b0;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt_q == MID_BIT_TICK) begin
                        tick_cnt_d = '0;
                        state_d    = rx_sync ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d         = '0;
                        shift_d[bit_idx_q] = rx_sync;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_d = '0;
                            state_d   = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d     = '0;
                        par_err_pend_d = ((^shift_q) ^ rx_sync) != par_odd_q;
                        state_d        = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (tick) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d      = '0;
                        data_out_d      = shift_q;
                        parity_error_d  = par_en_q & par_err_pend_q;
                        framing_error_d = ~rx_sync;
                        data_valid_d    = 1'b1;
                        state_d         = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            tick_cnt_q      <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            rate_q          <= BAUD_2400;
            par_en_q        <= 1'b0;
            par_odd_q       <= 1'b0;
            par_err_pend_q  <= 1'b0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            rate_q          <= rate_d;
            par_en_q        <= par_en_d;
            par_odd_q       <= par_odd_d;
            par_err_pend_q  <= par_err_pend_d;
            data_out_q      <= data_out_d;
            data_valid_q    <= data_valid_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_valid    = data_valid_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: drives serial frames at the four
// line rates and checks captured bytes, status flags, latency and reset.
`timescale 1ns/1ps
module tb_uart_rx;

    // Clocks per bit = 16 * (terminal count + 1).
    localparam int BIT_2400  = 20832;
    localparam int BIT_4800  = 10416;
    localparam int BIT_9600  = 5216;
    localparam int BIT_19200 = 2608;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic [1:0] baud_rate  = 2'b11;
    logic       parity_en  = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rx_serial  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       rx_busy;

    int n_cmp     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int vcount    = 0;
    int last_vcyc = 0;
    int edge_cyc  = 0;
    int base      = 0;
    logic [7:0] vlog [0:15];

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .baud_rate     (baud_rate),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .rx_serial     (rx_serial),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    always #10 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Every high cycle of data_valid is logged, so a stretched pulse shows up as extra counts.
    always @(negedge clock) begin
        if (data_valid === 1'b1) begin
            vlog[vcount % 16] = data_out;
            last_vcyc = cyc;
            vcount++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        n_cmp++;
        assert (obs >= exp - tol && obs <= exp + tol) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (rx_busy !== 1'b0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, {31'd0, rx_busy}, 32'd0);
    endtask

    // mess=1 flips the rate/parity inputs after the start edge and restores them after the frame.
    task automatic send_frame(input logic [7:0] b, input int bclk, input bit has_par,
                              input bit par_bit, input bit stop_bit, input bit mess);
        logic [1:0] br_save;
        logic       pe_save;
        logic       po_save;
        br_save = baud_rate;
        pe_save = parity_en;
        po_save = parity_odd;
        @(negedge clock);
        rx_serial = 1'b0;
        edge_cyc  = cyc;
        repeat (20) @(negedge clock);
        if (mess) begin
            baud_rate  = ~baud_rate;
            parity_en  = ~parity_en;
            parity_odd = ~parity_odd;
        end
        repeat (bclk - 20) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (bclk) @(negedge clock);
        end
        if (has_par) begin
            rx_serial = par_bit;
            repeat (bclk) @(negedge clock);
        end
        rx_serial = stop_bit;
        repeat (bclk) @(negedge clock);
        rx_serial = 1'b1;
        if (mess) begin
            baud_rate  = br_save;
            parity_en  = pe_save;
            parity_odd = po_save;
        end
    endtask

    initial begin
        logic [7:0] abort_byte;
        abort_byte = 8'hA3;

        repeat (5) @(negedge clock);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_parity_error", {31'd0, parity_error}, 32'd0);
        check("rst_framing_error", {31'd0, framing_error}, 32'd0);
        check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        $display("step reset: released");

        // 19200, no parity, 0x55; inputs disturbed mid-frame must be ignored.
        baud_rate = 2'b11; parity_en = 1'b0; parity_odd = 1'b0;
        base = vcount;
        send_frame(8'h55, BIT_19200, 1'b0, 1'b0, 1'b1, 1'b1);
        check("b19200_count", vcount, base + 1);
        check("b19200_data", {24'd0, vlog[base % 16]}, 32'h55);
        check("b19200_perr", {31'd0, parity_error}, 32'd0);
        check("b19200_ferr", {31'd0, framing_error}, 32'd0);
        check_near("b19200_latency", last_vcyc - edge_cyc, 152 * 163 + 2, 163);
        wait_idle("b19200_idle", 200);
        $display("frame 19200 0x55: data_out=%02h pe=%0d fe=%0d", data_out, parity_error, framing_error);

        // 9600, even parity, 0xA5 with parity bit 0.
        baud_rate = 2'b10; parity_en = 1'b1; parity_odd = 1'b0;
        base = vcount;
        send_frame(8'hA5, BIT_9600, 1'b1, 1'b0, 1'b1, 1'b0);
        check("even_count", vcount, base + 1);
        check("even_data", {24'd0, data_out}, 32'hA5);
        check("even_perr", {31'd0, parity_error}, 32'd0);
        check_near("even_latency", last_vcyc - edge_cyc, 168 * 326 + 2, 326);
        wait_idle("even_idle", 200);
        $display("frame 9600 even 0xA5: data_out=%02h pe=%0d", data_out, parity_error);

        // Same bits, odd parity: the parity bit is now wrong.
        parity_odd = 1'b1;
        base = vcount;
        send_frame(8'hA5, BIT_9600, 1'b1, 1'b0, 1'b1, 1'b0);
        check("odd_count", vcount, base + 1);
        check("odd_data", {24'd0, data_out}, 32'hA5);
        check("odd_perr", {31'd0, parity_error}, 32'd1);
        check("odd_ferr", {31'd0, framing_error}, 32'd0);
        wait_idle("odd_idle", 200);
        $display("frame 9600 odd 0xA5: data_out=%02h pe=%0d", data_out, parity_error);

        // 2400, no parity, 0x3C with the stop bit held low.
        baud_rate = 2'b00; parity_en = 1'b0; parity_odd = 1'b0;
        base = vcount;
        send_frame(8'h3C, BIT_2400, 1'b0, 1'b0, 1'b0, 1'b0);
        check("frm_count", vcount, base + 1);
        check("frm_data", {24'd0, data_out}, 32'h3C);
        check("frm_ferr", {31'd0, framing_error}, 32'd1);
        check("frm_perr", {31'd0, parity_error}, 32'd0);
        wait_idle("frm_idle", BIT_2400);
        check("frm_no_extra", vcount, base + 1);
        $display("frame 2400 0x3C stop=0: data_out=%02h fe=%0d", data_out, framing_error);

        // 9600, 1000-clock low glitch on an idle line.
        baud_rate = 2'b10;
        base = vcount;
        @(negedge clock);
        rx_serial = 1'b0;
        repeat (500) @(negedge clock);
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        repeat (500) @(negedge clock);
        rx_serial = 1'b1;
        wait_idle("glitch_idle", BIT_9600);
        repeat (BIT_9600) @(negedge clock);
        check("glitch_no_valid", vcount, base);
        check("glitch_data_held", {24'd0, data_out}, 32'h3C);
        check("glitch_ferr_held", {31'd0, framing_error}, 32'd1);
        $display("glitch 9600: busy=%0d data_out=%02h pulses=%0d", rx_busy, data_out, vcount - base);

        // 4800, back-to-back 0x12 then 0x34.
        baud_rate = 2'b01;
        base = vcount;
        send_frame(8'h12, BIT_4800, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h34, BIT_4800, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_count", vcount, base + 2);
        check("b2b_first", {24'd0, vlog[base % 16]}, 32'h12);
        check("b2b_second", {24'd0, vlog[(base + 1) % 16]}, 32'h34);
        wait_idle("b2b_idle", 200);
        $display("back-to-back 4800: first=%02h second=%02h", vlog[base % 16], vlog[(base + 1) % 16]);

        // 19200, reset in the middle of data bit 4, then a clean 0xF0.
        baud_rate = 2'b11;
        base = vcount;
        @(negedge clock);
        rx_serial = 1'b0;
        repeat (BIT_19200) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx_serial = abort_byte[i];
            repeat (BIT_19200) @(negedge clock);
        end
        rx_serial = abort_byte[4];
        repeat (BIT_19200 / 2) @(negedge clock);
        check("abort_busy_before", {31'd0, rx_busy}, 32'd1);
        reset = 1'b1;
        rx_serial = 1'b1;
        #1;
        check("abort_busy_async", {31'd0, rx_busy}, 32'd0);
        check("abort_data_async", {24'd0, data_out}, 32'h00);
        check("abort_ferr_async", {31'd0, framing_error}, 32'd0);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (2 * BIT_19200) @(negedge clock);
        check("abort_no_valid", vcount, base);
        send_frame(8'hF0, BIT_19200, 1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_next_count", vcount, base + 1);
        check("abort_next_data", {24'd0, data_out}, 32'hF0);
        wait_idle("abort_idle", 200);
        $display("reset abort 19200: next data_out=%02h pulses=%0d", data_out, vcount - base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
